mod_updown_counter: RTL and testbench

Parametrised up/down counter with a configurable modulus, synchronous load and clear, and a wrap-or-saturate mode. Counting is gated by an enable. It generalises the team's basic enable counter for timers, address generators and event tallies. Events are reported through a registered terminal-count pulse, a zero flag and an optional sticky overflow flag.

---
 rtl/mod_cntr_pkg.sv | 15 +
 rtl/mod_cntr_step.sv | 49 ++++
 rtl/mod_updown_counter.sv | 75 +++++++
 tb/tb_mod_updown_counter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_cntr_pkg.sv
// Shared constants and terminal-value helper for the modulo up/down counter.
package mod_cntr_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam int   MAX_W     = 32;

  // Last legal count (MOD_VAL-1), one bit wider than the widest counter so 2**W moduli fit.
  function automatic logic [MAX_W:0] term_val(input longint unsigned mod_val);
    return (MAX_W+1)'(mod_val - 64'd1);
  endfunction

endpackage

// File: rtl/mod_cntr_step.sv
// Combinational next-count for one enabled step: wraps or holds at the range ends
// and flags the terminal event.
module mod_cntr_step
  import mod_cntr_pkg::*;
#(
  parameter int              CNTR_WIDTH = 8,
  parameter longint unsigned MOD_VAL    = 64'd1 << CNTR_WIDTH
) (
  input  logic [CNTR_WIDTH-1:0] cnt,
  input  logic                  dir,
  input  logic                  mode,
  output logic [CNTR_WIDTH-1:0] nxt_cnt,
  output logic                  term
);

  localparam logic [MAX_W:0]      TERM_FULL = term_val(MOD_VAL);
  localparam logic [CNTR_WIDTH:0] TERM      = TERM_FULL[CNTR_WIDTH:0];
  localparam logic [CNTR_WIDTH-1:0] TOP     = TERM[CNTR_WIDTH-1:0];

  logic at_top;
  logic at_bot;

  assign at_top = ({1'b0, cnt} == TERM);
  assign at_bot = (cnt == '0);

  always_comb begin
    nxt_cnt = cnt;
    term    = 1'b0;
    case (dir)
      DIR_UP: begin
        if (at_top) begin
          term = 1'b1;
          if (mode == MODE_WRAP) nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt + CNTR_WIDTH'(1);
        end
      end
      DIR_DN: begin
        if (at_bot) begin
          term = 1'b1;
          if (mode == MODE_WRAP) nxt_cnt = TOP;
        end else begin
          nxt_cnt = cnt - CNTR_WIDTH'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter, clr > ld > en, registered count and terminal pulse (1-cycle latency, no backpressure).
// Define MOD_CNTR_OVF_STICKY_EN to add the sticky overflow flag (ovf_clr/ovf_o).
module mod_updown_counter
  import mod_cntr_pkg::*;
#(
  parameter int              CNTR_WIDTH = 8,
  parameter longint unsigned MOD_VAL    = 64'd1 << CNTR_WIDTH,
  parameter int              SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [CNTR_WIDTH-1:0] ld_val,
  output logic [CNTR_WIDTH-1:0] cntr_o,
  output logic                  tc_o,
`ifdef MOD_CNTR_OVF_STICKY_EN
  output logic                  zero_o,
  input  logic                  ovf_clr,
  output logic                  ovf_o
`else
  output logic                  zero_o
`endif
);

  localparam logic [MAX_W:0]        TERM_FULL = term_val(MOD_VAL);
  localparam logic [CNTR_WIDTH:0]   TERM      = TERM_FULL[CNTR_WIDTH:0];
  localparam logic [CNTR_WIDTH-1:0] TOP       = TERM[CNTR_WIDTH-1:0];
  localparam logic                  MODE      = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [CNTR_WIDTH-1:0] step_cnt;
  logic                  step_term;
  logic [CNTR_WIDTH-1:0] ld_clamped;
  logic                  tc_ev;

  mod_cntr_step #(
    .CNTR_WIDTH (CNTR_WIDTH),
    .MOD_VAL    (MOD_VAL)
  ) u_step (
    .cnt     (cntr_o),
    .dir     (dir),
    .mode    (MODE),
    .nxt_cnt (step_cnt),
    .term    (step_term)
  );

  assign ld_clamped = ({1'b0, ld_val} > TERM) ? TOP : ld_val;
  // A terminal event only counts when the step actually wins the priority mux.
  assign tc_ev      = en && !clr && !ld && step_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr_o <= '0;
      tc_o   <= 1'b0;
    end else begin
      tc_o <= tc_ev;
      if (clr)     cntr_o <= '0;
      else if (ld) cntr_o <= ld_clamped;
      else if (en) cntr_o <= step_cnt;
    end
  end

  assign zero_o = (cntr_o == '0);

`ifdef MOD_CNTR_OVF_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_o <= 1'b0;
    else if (tc_ev)   ovf_o <= 1'b1;
    else if (ovf_clr) ovf_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench: three counter configurations against an arithmetic reference model plus directed vectors.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, dir, clr, ld, ovf_clr;
  logic [7:0] ld_val;
  logic [3:0] a_cnt, b_cnt;
  logic [7:0] c_cnt;
  logic       a_tc, b_tc, c_tc, a_zero, b_zero, c_zero;
`ifdef MOD_CNTR_OVF_STICKY_EN
  logic       a_ovf, b_ovf, c_ovf;
`endif

  int errors = 0;
  int checks = 0;

  int m_cnt[3];
  bit m_tc[3];
  bit m_ovf[3];
  int m_mod[3];
  bit m_sat[3];

  mod_updown_counter #(.CNTR_WIDTH(4), .MOD_VAL(10), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .ld(ld), .ld_val(ld_val[3:0]),
    .cntr_o(a_cnt), .tc_o(a_tc), .zero_o(a_zero)
`ifdef MOD_CNTR_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_o(a_ovf)
`endif
  );

  mod_updown_counter #(.CNTR_WIDTH(4), .MOD_VAL(10), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .ld(ld), .ld_val(ld_val[3:0]),
    .cntr_o(b_cnt), .tc_o(b_tc), .zero_o(b_zero)
`ifdef MOD_CNTR_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_o(b_ovf)
`endif
  );

  mod_updown_counter #(.CNTR_WIDTH(8), .MOD_VAL(256), .SATURATE(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .ld(ld), .ld_val(ld_val),
    .cntr_o(c_cnt), .tc_o(c_tc), .zero_o(c_zero)
`ifdef MOD_CNTR_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_o(c_ovf)
`endif
  );

  typedef struct {
    bit clr;
    bit ld;
    int ldv;
    bit en;
    bit dir;
    int exp_cnt;
    bit exp_tc;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: range arithmetic straight from the counting rules.
  function automatic void mstep(input int i, input int ldv);
    int m;
    int c;
    int n;
    bit ev;
    m  = m_mod[i];
    c  = m_cnt[i];
    n  = c;
    ev = 1'b0;
    if (clr) n = 0;
    else if (ld) n = (ldv >= m) ? m - 1 : ldv;
    else if (en) begin
      if (dir) begin
        ev = (c + 1 >= m);
        n  = m_sat[i] ? (ev ? m - 1 : c + 1) : (c + 1) % m;
      end else begin
        ev = (c == 0);
        n  = m_sat[i] ? (ev ? 0 : c - 1) : (c + m - 1) % m;
      end
    end
    m_cnt[i] = n;
    m_tc[i]  = ev;
    if (ev) m_ovf[i] = 1'b1;
    else if (ovf_clr) m_ovf[i] = 1'b0;
  endfunction

  task automatic check_all();
    check("a_cnt", int'(a_cnt), m_cnt[0]);
    check("a_tc", int'(a_tc), int'(m_tc[0]));
    check("a_zero", int'(a_zero), int'(m_cnt[0] == 0));
    check("b_cnt", int'(b_cnt), m_cnt[1]);
    check("b_tc", int'(b_tc), int'(m_tc[1]));
    check("b_zero", int'(b_zero), int'(m_cnt[1] == 0));
    check("c_cnt", int'(c_cnt), m_cnt[2]);
    check("c_tc", int'(c_tc), int'(m_tc[2]));
    check("c_zero", int'(c_zero), int'(m_cnt[2] == 0));
`ifdef MOD_CNTR_OVF_STICKY_EN
    check("a_ovf", int'(a_ovf), int'(m_ovf[0]));
    check("b_ovf", int'(b_ovf), int'(m_ovf[1]));
    check("c_ovf", int'(c_ovf), int'(m_ovf[2]));
`endif
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) mstep(i, (i == 2) ? int'(ld_val) : int'(ld_val[3:0]));
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit e, input bit d);
    clr    = c;
    ld     = l;
    ld_val = 8'(lv);
    en     = e;
    dir    = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 1'b0;
      m_ovf[i] = 1'b0;
    end
  endtask

  initial begin
    m_mod = '{10, 10, 256};
    m_sat = '{1'b0, 1'b1, 1'b0};
    model_reset();

    //          clr  ld  ldv en  dir cnt tc
    tbl[0]  = '{1'b0, 1'b1, 7,  1'b0, 1'b1, 7, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 0,  1'b1, 1'b1, 8, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 0,  1'b1, 1'b1, 9, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 0,  1'b1, 1'b1, 0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 9, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 8, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 5,  1'b1, 1'b1, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 12, 1'b0, 1'b1, 9, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 0,  1'b0, 1'b1, 9, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 0,  1'b0, 1'b1, 9, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 0,  1'b0, 1'b1, 9, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 0,  1'b1, 1'b1, 0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 15, 1'b0, 1'b0, 9, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 3,  1'b1, 1'b1, 3, 1'b0};

    rst     = 1'b0;
    ovf_clr = 1'b0;
    drive(0, 0, 0, 0, 1);
    #1 rst = 1'b1;
    #2;
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // wrap up from reset: 1..9 then 0 with tc
    drive(0, 0, 0, 1, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("wrap_up_cnt", int'(a_cnt), k % 10);
      check("wrap_up_tc", int'(a_tc), int'(k == 10));
    end

    // asynchronous reset in the middle of a cycle
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_cnt", int'(a_cnt), 0);
    check("arst_zero", int'(a_zero), 1);
    check("arst_c_cnt", int'(c_cnt), 0);
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // wrap down from 0: 9,8,...,0,9
    drive(0, 0, 0, 1, 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("wrap_dn_cnt", int'(a_cnt), (20 - k) % 10);
      check("wrap_dn_tc", int'(a_tc), int'(k == 1 || k == 11));
    end

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].ldv, tbl[i].en, tbl[i].dir);
      tick();
      check($sformatf("vec%0d_cnt", i), int'(a_cnt), tbl[i].exp_cnt);
      check($sformatf("vec%0d_tc", i), int'(a_tc), int'(tbl[i].exp_tc));
    end

    // saturate: from 7 up for 5 enabled cycles
    drive(0, 1, 7, 0, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("sat_cnt", int'(b_cnt), (k == 1) ? 8 : 9);
      check("sat_tc", int'(b_tc), int'(k >= 3));
    end

    // full 8-bit range wrap both ways
    drive(0, 1, 255, 0, 1);
    tick();
    check("full_ld", int'(c_cnt), 255);
    drive(0, 0, 0, 1, 1);
    tick();
    check("full_up_cnt", int'(c_cnt), 0);
    check("full_up_tc", int'(c_tc), 1);
    drive(0, 0, 0, 1, 0);
    tick();
    check("full_dn_cnt", int'(c_cnt), 255);
    check("full_dn_tc", int'(c_tc), 1);

`ifdef MOD_CNTR_OVF_STICKY_EN
    drive(0, 0, 0, 0, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr_init", int'(a_ovf), 0);
    drive(0, 1, 9, 0, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    check("ovf_set", int'(a_ovf), 1);
    drive(1, 0, 0, 0, 1);
    tick();
    check("ovf_through_clr", int'(a_ovf), 1);
    drive(0, 0, 0, 0, 1);
    ovf_clr = 1'b1;
    tick();
    check("ovf_cleared", int'(a_ovf), 0);
    ovf_clr = 1'b0;
    drive(0, 1, 9, 0, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    ovf_clr = 1'b1;
    tick();
    check("ovf_set_wins", int'(a_ovf), 1);
    ovf_clr = 1'b0;
`endif

    for (int n = 0; n < 600; n++) begin
      clr     = ($urandom_range(0, 19) == 0);
      ld      = ($urandom_range(0, 9) == 0);
      ld_val  = 8'($urandom_range(0, 255));
      en      = ($urandom_range(0, 3) != 0);
      dir     = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
